kalman_update_seq: RTL and testbench

//   Parametrised Kalman-filter measurement-update engine: x = xhat + K*(z - H*xhat), P = Phat - K*(H*Phat).
//   A single time-multiplexed MAC replaces per-step matrix instances. Adds saturation reporting and a busy flag.

---
 rtl/kf_pkg.sv | 55 +++++
 rtl/kf_mac.sv | 49 ++++
 rtl/kalman_update_seq.sv | 184 ++++++++++++++++++
 tb/tb_kalman_update_seq.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/kf_pkg.sv
// Shared definitions for the Kalman measurement-update engine.
//   kf_state_t : sequencer state encoding
//   KF_*       : default Q-format and accumulator widths
//   kf_rnd     : round half up, then arithmetic shift right by the fraction width
//   kf_sat     : clamp a wide signed value into a w-bit two's-complement range
//   kf_sat_hit : reports whether kf_sat would clamp
//   kf_idx     : row-major flat index helper
package kf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INNOV  = 3'd1,
    ST_XUPD   = 3'd2,
    ST_HP     = 3'd3,
    ST_PUPD   = 3'd4,
    ST_FINISH = 3'd5
  } kf_state_t;

  localparam int KF_DATA_W = 32;
  localparam int KF_FRAC_W = 12;
  localparam int KF_ACC_W  = 72;
  // Working width for the rounding/saturation helpers; ACC_W must not exceed it.
  localparam int KF_MAXW   = 128;

  typedef logic signed [KF_MAXW-1:0] kf_wide_t;

  function automatic kf_wide_t kf_rnd(input kf_wide_t a, input int frac);
    kf_wide_t half;
    half = kf_wide_t'(1) <<< (frac - 1);
    return (a + half) >>> frac;
  endfunction

  function automatic kf_wide_t kf_sat(input kf_wide_t v, input int w);
    kf_wide_t hi;
    kf_wide_t lo;
    hi = (kf_wide_t'(1) <<< (w - 1)) - kf_wide_t'(1);
    lo = -hi - kf_wide_t'(1);
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

  function automatic logic kf_sat_hit(input kf_wide_t v, input int w);
    kf_wide_t hi;
    kf_wide_t lo;
    hi = (kf_wide_t'(1) <<< (w - 1)) - kf_wide_t'(1);
    lo = -hi - kf_wide_t'(1);
    return (v > hi) || (v < lo);
  endfunction

  function automatic int kf_idx(input int r, input int c, input int ncols);
    return r * ncols + c;
  endfunction

endpackage

// File: rtl/kf_mac.sv
// Single multiply-accumulate unit with a combinational round/saturate output stage.
//   clk, rst_n : clock, asynchronous active-low reset (clears the accumulator)
//   en         : accumulate a*b this cycle
//   clr        : with en, start a new sum (load a*b instead of adding)
//   a, b       : signed DATA_W operands, product sign-extended to ACC_W
//   base, sub  : res = sat(base +/- rnd(acc))
//   res, sat   : saturated result and clamp strobe, both from the current accumulator
module kf_mac import kf_pkg::*; #(
  parameter int DATA_W = KF_DATA_W,
  parameter int FRAC_W = KF_FRAC_W,
  parameter int ACC_W  = KF_ACC_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     clr,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic signed [DATA_W-1:0] base,
  input  logic                     sub,
  output logic signed [DATA_W-1:0] res,
  output logic                     sat
);

  logic signed [2*DATA_W-1:0] prod_p0;
  logic signed [ACC_W-1:0]    acc_p1;
  kf_wide_t                   rnd_p1;
  kf_wide_t                   sum_p1;

  assign prod_p0 = a * b;

  // stage p0 -> p1: accumulate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_p1 <= '0;
    end else if (en) begin
      acc_p1 <= clr ? ACC_W'(prod_p0) : acc_p1 + ACC_W'(prod_p0);
    end
  end

  // stage p1: round, combine with base, clamp
  always_comb begin
    rnd_p1 = kf_rnd(kf_wide_t'(acc_p1), FRAC_W);
    sum_p1 = sub ? kf_wide_t'(base) - rnd_p1 : kf_wide_t'(base) + rnd_p1;
    res    = DATA_W'(kf_sat(sum_p1, DATA_W));
    sat    = kf_sat_hit(sum_p1, DATA_W);
  end

endmodule

// File: rtl/kalman_update_seq.sv
// Sequential Kalman measurement update: x = xhat + K(z - H xhat), P = Phat - K(H Phat).
// One shared MAC walks each phase element by element: inner-length MAC cycles, then one
// write cycle that stores the rounded/saturated element into scratch.
//   clk, rst_n              : clock, asynchronous active-low reset
//   start                   : accepted only in IDLE; all input buses captured on that edge
//   xhat/z/H/K/Phat_flat    : packed row-major operand buses
//   x_upd_flat, P_upd_flat  : registered results, updated only in FINISH
//   busy                    : sequencer not idle
//   done                    : one-cycle pulse with fresh results
//   sat_flag                : some element clamped during the last run
module kalman_update_seq import kf_pkg::*; #(
  parameter int N_STATE = 6,
  parameter int N_MEAS  = 4,
  parameter int DATA_W  = KF_DATA_W,
  parameter int FRAC_W  = KF_FRAC_W,
  parameter int ACC_W   = KF_ACC_W
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic [N_STATE*DATA_W-1:0]            xhat_flat,
  input  logic [N_MEAS*DATA_W-1:0]             z_flat,
  input  logic [N_MEAS*N_STATE*DATA_W-1:0]     H_flat,
  input  logic [N_STATE*N_MEAS*DATA_W-1:0]     K_flat,
  input  logic [N_STATE*N_STATE*DATA_W-1:0]    Phat_flat,
  output logic [N_STATE*DATA_W-1:0]            x_upd_flat,
  output logic [N_STATE*N_STATE*DATA_W-1:0]    P_upd_flat,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 sat_flag
);

  localparam int N = N_STATE;
  localparam int M = N_MEAS;
  localparam int W = DATA_W;

  kf_state_t state, state_nxt;

  logic [N*W-1:0]   xhat_q, xn_s;
  logic [M*W-1:0]   z_q, y_s;
  logic [M*N*W-1:0] h_q, t_s;
  logic [N*M*W-1:0] k_q;
  logic [N*N*W-1:0] p_q, pn_s;

  int r_cnt, c_cnt, k_cnt;
  int n_rows, n_cols, n_inner, ki;

  logic in_phase, wr_cyc, phase_last;
  logic mac_en, mac_clr, mac_wr, mac_sub, mac_sat;
  logic signed [W-1:0] mac_a, mac_b, mac_base, mac_res;

  // Loop bounds of the current phase: rows x cols elements, n_inner MAC cycles each.
  always_comb begin
    n_rows  = 1;
    n_cols  = 1;
    n_inner = 1;
    case (state)
      ST_INNOV: begin n_rows = M; n_inner = N; end
      ST_XUPD:  begin n_rows = N; n_inner = M; end
      ST_HP:    begin n_rows = M; n_cols = N; n_inner = N; end
      ST_PUPD:  begin n_rows = N; n_cols = N; n_inner = M; end
      default: ;
    endcase
  end

  assign in_phase   = (state == ST_INNOV) || (state == ST_XUPD) ||
                      (state == ST_HP)    || (state == ST_PUPD);
  assign wr_cyc     = (k_cnt == n_inner);
  assign phase_last = wr_cyc && (c_cnt == n_cols - 1) && (r_cnt == n_rows - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start)      state_nxt = ST_INNOV;
      ST_INNOV:  if (phase_last) state_nxt = ST_XUPD;
      ST_XUPD:   if (phase_last) state_nxt = ST_HP;
      ST_HP:     if (phase_last) state_nxt = ST_PUPD;
      ST_PUPD:   if (phase_last) state_nxt = ST_FINISH;
      ST_FINISH:                 state_nxt = ST_IDLE;
      default:                   state_nxt = ST_IDLE;
    endcase
  end

  // Operand muxes. ki is clamped on the write cycle so no select runs past its bus.
  always_comb begin
    busy     = (state != ST_IDLE);
    ki       = (k_cnt < n_inner) ? k_cnt : 0;
    mac_a    = '0;
    mac_b    = '0;
    mac_base = '0;
    mac_sub  = 1'b0;
    case (state)
      ST_INNOV: begin
        mac_a    = h_q[kf_idx(r_cnt, ki, N)*W +: W];
        mac_b    = xhat_q[ki*W +: W];
        mac_base = z_q[r_cnt*W +: W];
        mac_sub  = 1'b1;
      end
      ST_XUPD: begin
        mac_a    = k_q[kf_idx(r_cnt, ki, M)*W +: W];
        mac_b    = y_s[ki*W +: W];
        mac_base = xhat_q[r_cnt*W +: W];
      end
      ST_HP: begin
        mac_a    = h_q[kf_idx(r_cnt, ki, N)*W +: W];
        mac_b    = p_q[kf_idx(ki, c_cnt, N)*W +: W];
      end
      ST_PUPD: begin
        mac_a    = k_q[kf_idx(r_cnt, ki, M)*W +: W];
        mac_b    = t_s[kf_idx(ki, c_cnt, N)*W +: W];
        mac_base = p_q[kf_idx(r_cnt, c_cnt, N)*W +: W];
        mac_sub  = 1'b1;
      end
      default: ;
    endcase
    mac_en  = in_phase && !wr_cyc;
    mac_clr = in_phase && !wr_cyc && (k_cnt == 0);
    mac_wr  = in_phase && wr_cyc;
  end

  kf_mac #(.DATA_W(W), .FRAC_W(FRAC_W), .ACC_W(ACC_W)) u_mac (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (mac_en),
    .clr  (mac_clr),
    .a    (mac_a),
    .b    (mac_b),
    .base (mac_base),
    .sub  (mac_sub),
    .res  (mac_res),
    .sat  (mac_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 0; c_cnt <= 0; k_cnt <= 0;
      xhat_q <= '0; z_q <= '0; h_q <= '0; k_q <= '0; p_q <= '0;
      y_s <= '0; t_s <= '0; xn_s <= '0; pn_s <= '0;
      x_upd_flat <= '0; P_upd_flat <= '0;
      done <= 1'b0; sat_flag <= 1'b0;
    end else begin
      done <= (state == ST_FINISH);
      if (state == ST_IDLE && start) begin
        xhat_q <= xhat_flat; z_q <= z_flat; h_q <= H_flat; k_q <= K_flat; p_q <= Phat_flat;
        sat_flag <= 1'b0;
        r_cnt <= 0; c_cnt <= 0; k_cnt <= 0;
      end
      // Counters: k innermost, then c, then r; all return to 0 at the end of a phase.
      if (in_phase) begin
        if (!wr_cyc) begin
          k_cnt <= k_cnt + 1;
        end else begin
          k_cnt <= 0;
          if (c_cnt == n_cols - 1) begin
            c_cnt <= 0;
            r_cnt <= (r_cnt == n_rows - 1) ? 0 : r_cnt + 1;
          end else begin
            c_cnt <= c_cnt + 1;
          end
        end
      end
      if (mac_wr) begin
        case (state)
          ST_INNOV: y_s[r_cnt*W +: W] <= mac_res;
          ST_XUPD:  xn_s[r_cnt*W +: W] <= mac_res;
          ST_HP:    t_s[kf_idx(r_cnt, c_cnt, N)*W +: W] <= mac_res;
          ST_PUPD:  pn_s[kf_idx(r_cnt, c_cnt, N)*W +: W] <= mac_res;
          default: ;
        endcase
        if (mac_sat) sat_flag <= 1'b1;
      end
      if (state == ST_FINISH) begin
        x_upd_flat <= xn_s;
        P_upd_flat <= pn_s;
      end
    end
  end

endmodule

// File: tb/tb_kalman_update_seq.sv
module tb_kalman_update_seq;

  localparam int W    = 32;
  localparam int LAT6 = 407;
  localparam int LAT2 = 22;
  localparam logic [31:0] ONE = 32'h0000_1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // N=6, M=4 instance
  logic            start6 = 1'b0;
  logic [6*W-1:0]  xh6, xo6, ex6;
  logic [4*W-1:0]  z6;
  logic [24*W-1:0] h6, k6;
  logic [36*W-1:0] p6, po6, ep6;
  logic            busy6, done6, sat6;

  // N=2, M=1 instance
  logic            start2 = 1'b0;
  logic [2*W-1:0]  xh2, xo2, ex2, h2, k2;
  logic [W-1:0]    z2;
  logic [4*W-1:0]  p2, po2, ep2;
  logic            busy2, done2, sat2;

  kalman_update_seq #(.N_STATE(6), .N_MEAS(4), .DATA_W(32), .FRAC_W(12), .ACC_W(72)) u6 (
    .clk(clk), .rst_n(rst_n), .start(start6), .xhat_flat(xh6), .z_flat(z6), .H_flat(h6),
    .K_flat(k6), .Phat_flat(p6), .x_upd_flat(xo6), .P_upd_flat(po6), .busy(busy6),
    .done(done6), .sat_flag(sat6));

  kalman_update_seq #(.N_STATE(2), .N_MEAS(1), .DATA_W(32), .FRAC_W(12), .ACC_W(72)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .xhat_flat(xh2), .z_flat(z2), .H_flat(h2),
    .K_flat(k2), .Phat_flat(p2), .x_upd_flat(xo2), .P_upd_flat(po2), .busy(busy2),
    .done(done2), .sat_flag(sat2));

  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic chk_p6(input string tag);
    for (int r = 0; r < 6; r++)
      chk($sformatf("%s_row%0d", tag, r), 256'(po6[r*6*W +: 6*W]), 256'(ep6[r*6*W +: 6*W]));
  endtask

  task automatic clr_in6();
    xh6 = '0; z6 = '0; h6 = '0; k6 = '0; p6 = '0;
  endtask

  // H = [I4|0], K = H^T, xhat = 0, z = [1,2,3,4], Phat = I6
  task automatic setup_ident();
    clr_in6();
    for (int r = 0; r < 4; r++) begin
      h6[(r*6+r)*W +: W] = ONE;
      k6[(r*4+r)*W +: W] = ONE;
      z6[r*W +: W]       = 32'((r + 1) << 12);
    end
    for (int i = 0; i < 6; i++) p6[(i*6+i)*W +: W] = ONE;
    ex6 = '0; ep6 = '0;
    for (int r = 0; r < 4; r++) ex6[r*W +: W] = 32'((r + 1) << 12);
    ep6[(4*6+4)*W +: W] = ONE;
    ep6[(5*6+5)*W +: W] = ONE;
  endtask

  task automatic scramble6();
    for (int i = 0; i < 6; i++)  xh6[i*W +: W] = $urandom;
    for (int i = 0; i < 4; i++)  z6[i*W +: W]  = $urandom;
    for (int i = 0; i < 24; i++) begin h6[i*W +: W] = $urandom; k6[i*W +: W] = $urandom; end
    for (int i = 0; i < 36; i++) p6[i*W +: W]  = $urandom;
  endtask

  // Accept on one edge, then count edges until done is seen (bounded).
  task automatic run_dut(input bit big, input bit scr, output int lat, output logic bsy);
    @(negedge clk);
    if (big) start6 = 1'b1; else start2 = 1'b1;
    @(posedge clk); #1;
    start6 = 1'b0; start2 = 1'b0;
    bsy = big ? busy6 : busy2;
    if (scr) scramble6();
    lat = 0;
    while (lat < 1000) begin
      @(posedge clk); #1;
      lat++;
      if (big ? done6 : done2) break;
    end
  endtask

  int   lat, ndone, first;
  logic bsy;

  initial begin
    clr_in6();
    xh2 = '0; z2 = '0; h2 = '0; k2 = '0; p2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 256'(busy6), 256'(0));
    chk("rst_done", 256'(done6), 256'(0));
    chk("rst_sat",  256'(sat6),  256'(0));
    chk("rst_x",    256'(xo6),   256'(0));
    chk("rst_p0",   256'(po6[6*W-1:0]), 256'(0));
    @(negedge clk); rst_n = 1'b1;

    // K = 0, H = 0, z = 0: pass-through of random xhat/Phat
    clr_in6();
    for (int i = 0; i < 6; i++)  xh6[i*W +: W] = $urandom;
    for (int i = 0; i < 36; i++) p6[i*W +: W]  = $urandom;
    ex6 = xh6; ep6 = p6;
    run_dut(1'b1, 1'b0, lat, bsy);
    chk("k0_lat",  256'(lat), 256'(LAT6));
    chk("k0_busy_after_accept", 256'(bsy), 256'(1));
    chk("k0_busy_at_done", 256'(busy6), 256'(0));
    chk("k0_x", 256'(xo6), 256'(ex6));
    chk_p6("k0_p");
    chk("k0_sat", 256'(sat6), 256'(0));
    @(posedge clk); #1;
    chk("k0_done_pulse", 256'(done6), 256'(0));

    // Identity update, inputs scrambled right after accept
    setup_ident();
    run_dut(1'b1, 1'b1, lat, bsy);
    chk("id_lat", 256'(lat), 256'(LAT6));
    chk("id_x", 256'(xo6), 256'(ex6));
    chk_p6("id_p");
    chk("id_sat", 256'(sat6), 256'(0));

    // Rounding: y0 = -rnd(0.5 * 1 LSB) = -1 LSB, x'0 = 1 + rnd(1.0 * -1 LSB) = 0
    clr_in6();
    h6[0 +: W] = 32'h0000_0800;
    xh6[0 +: W] = 32'h0000_0001;
    k6[0 +: W] = ONE;
    ex6 = '0; ep6 = '0;
    run_dut(1'b1, 1'b0, lat, bsy);
    chk("rnd_x", 256'(xo6), 256'(ex6));
    chk("rnd_sat", 256'(sat6), 256'(0));

    // Saturation: T00 = -(2^31-1), P'00 = (2^31-1) + (2^31-1) clamps
    clr_in6();
    h6[0 +: W] = 32'hFFFF_F000;
    k6[0 +: W] = ONE;
    p6[0 +: W] = 32'h7FFF_FFFF;
    ex6 = '0; ep6 = p6;
    run_dut(1'b1, 1'b0, lat, bsy);
    chk("sat_p00", 256'(po6[0 +: W]), 256'(32'h7FFF_FFFF));
    chk_p6("sat_p");
    chk("sat_flag", 256'(sat6), 256'(1));

    setup_ident();
    run_dut(1'b1, 1'b0, lat, bsy);
    chk("clean_sat", 256'(sat6), 256'(0));
    chk("clean_x", 256'(xo6), 256'(ex6));

    // start pulses at cycles 5 and 100 of a run are ignored
    clr_in6();
    for (int i = 0; i < 6; i++)  xh6[i*W +: W] = $urandom;
    for (int i = 0; i < 36; i++) p6[i*W +: W]  = $urandom;
    ex6 = xh6; ep6 = p6;
    @(negedge clk); start6 = 1'b1;
    @(posedge clk); #1; start6 = 1'b0;
    ndone = 0; first = 0;
    for (int i = 1; i <= LAT6 + 30; i++) begin
      @(posedge clk); #1;
      if (done6) begin ndone++; if (first == 0) first = i; end
      start6 = (i == 4 || i == 99);
    end
    start6 = 1'b0;
    chk("pulse_ndone", 256'(ndone), 256'(1));
    chk("pulse_lat", 256'(first), 256'(LAT6));
    chk("pulse_x", 256'(xo6), 256'(ex6));
    chk_p6("pulse_p");

    // Reset in the middle of a run
    setup_ident();
    @(negedge clk); start6 = 1'b1;
    @(posedge clk); #1; start6 = 1'b0;
    repeat (200) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mrst_x", 256'(xo6), 256'(0));
    chk("mrst_p0", 256'(po6[6*W-1:0]), 256'(0));
    chk("mrst_busy", 256'(busy6), 256'(0));
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < LAT6 + 20; i++) begin
      @(posedge clk); #1;
      if (done6) ndone++;
    end
    chk("mrst_no_done", 256'(ndone), 256'(0));
    run_dut(1'b1, 1'b0, lat, bsy);
    chk("mrst_fresh_lat", 256'(lat), 256'(LAT6));
    chk("mrst_fresh_x", 256'(xo6), 256'(ex6));
    chk_p6("mrst_fresh_p");

    // N=2, M=1: H=[1,0.5], xhat=[2,1], z=3 -> y=0.5; K=[1;0.5]; P=diag(1,2)
    // T=[1,1]; x'=[2.5,1.25]; P'=[[0,-1],[-0.5,1.5]]
    xh2 = {32'h0000_1000, 32'h0000_2000};
    z2  = 32'h0000_3000;
    h2  = {32'h0000_0800, 32'h0000_1000};
    k2  = {32'h0000_0800, 32'h0000_1000};
    p2  = {32'h0000_2000, 32'h0, 32'h0, 32'h0000_1000};
    ex2 = {32'h0000_1400, 32'h0000_2800};
    ep2 = {32'h0000_1800, 32'hFFFF_F800, 32'hFFFF_F000, 32'h0000_0000};
    run_dut(1'b0, 1'b0, lat, bsy);
    chk("n2_lat", 256'(lat), 256'(LAT2));
    chk("n2_x", 256'(xo2), 256'(ex2));
    chk("n2_p", 256'(po2), 256'(ep2));
    chk("n2_sat", 256'(sat2), 256'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
